// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the multi-decade counter.
//   BCD_MAX / BCD_MIN : legal nibble extremes
//   bcd_clamp         : forces any non-decimal nibble (A..F) down to 9
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  function automatic logic [3:0] bcd_clamp(input logic [3:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade of the multi-digit counter.
// Ports:
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   load       : parallel load strobe, wins over step
//   load_nib   : nibble to load (clamped to 9 if non-decimal)
//   step       : advance this decade one position in the up_dn direction
//   up_dn      : 1 = count up, 0 = count down
//   sat        : whole counter is pinned at its limit, suppress the step
//   digit      : current decade value, always 0..9
//   at_lim     : digit sits at 9 (up) or 0 (down)
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_nib,
  input  logic       step,
  input  logic       up_dn,
  input  logic       sat,
  output logic [3:0] digit,
  output logic       at_lim
);

  // Decade register; the step wraps 9->0 / 0->9 so only decimal values are ever stored
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit <= BCD_MIN;
    end else if (load) begin
      digit <= bcd_clamp(load_nib);
    end else if (step && !sat) begin
      if (up_dn) begin
        digit <= (digit == BCD_MAX) ? BCD_MIN : digit + 4'd1;
      end else begin
        digit <= (digit == BCD_MIN) ? BCD_MAX : digit - 4'd1;
      end
    end
  end

  assign at_lim = up_dn ? (digit == BCD_MAX) : (digit == BCD_MIN);

endmodule

// File: rtl/bcd_counter_multi.sv
// Parametrised multi-digit synchronous BCD up/down counter with parallel load.
// Ports:
//   clk, rst_n : rising-edge clock, synchronous active-low reset
//   en         : count enable
//   up_dn      : 1 = count up, 0 = count down
//   load       : parallel load strobe (priority over en)
//   load_val   : BCD load value, digit 0 in bits [3:0]
//   count      : registered BCD value
//   carry      : one-cycle pulse while the wrapped value is shown
//   tc         : combinational terminal count, en & count at limit
//   load_err   : one-cycle pulse after a load carrying a nibble > 9
module bcd_counter_multi
  import bcd_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter bit WRAP_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry,
  output logic                  tc,
  output logic                  load_err
);

  logic [DIGITS-1:0] step;
  logic [DIGITS-1:0] at_lim;
  logic              all_lim;
  logic              sat;
  logic              wrap;
  logic              bad_nib;

  // Ripple-free step chain: a decade moves only when all lower decades sit at their limit
  assign step[0] = en;
  for (genvar k = 1; k < DIGITS; k++) begin : g_step
    assign step[k] = step[k-1] & at_lim[k-1];
  end

  assign all_lim = &at_lim;
  assign tc      = en & all_lim;
  assign sat     = ~WRAP_EN & all_lim;
  assign wrap    = WRAP_EN & tc & ~load;

  for (genvar k = 0; k < DIGITS; k++) begin : g_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_nib (load_val[4*k +: 4]),
      .step     (step[k]),
      .up_dn    (up_dn),
      .sat      (sat),
      .digit    (count[4*k +: 4]),
      .at_lim   (at_lim[k])
    );
  end

  // Flag any non-decimal nibble on the load bus
  always_comb begin
    bad_nib = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (load_val[4*k +: 4] > BCD_MAX) bad_nib = 1'b1;
    end
  end

  // carry is masked by its own previous value so back-to-back wraps
  // (single-decade direction flip) never hold it high for two cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= wrap & ~carry;
      load_err <= load & bad_nib;
    end
  end

endmodule

// File: tb/tb_bcd_counter_multi.sv
module tb_bcd_counter_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Main instance: DIGITS=2, WRAP_EN=1
  logic       en, up_dn, load;
  logic [7:0] load_val, count;
  logic       carry, tc, load_err;

  // Saturating instance: DIGITS=2, WRAP_EN=0
  logic       s_en, s_up_dn, s_load;
  logic [7:0] s_load_val, s_count;
  logic       s_carry, s_tc, s_load_err;

  // Chained pair: lo.tc -> hi.en
  logic       c_en, c_up_dn, c_load;
  logic [7:0] lo_val, hi_val, lo_count, hi_count;
  logic       lo_carry, lo_tc, lo_err, hi_carry, hi_tc, hi_err;

  // Single decade instance
  logic       o_en, o_up_dn, o_load;
  logic [3:0] o_val, o_count;
  logic       o_carry, o_tc, o_err;

  int n_cmp = 0;
  int n_err = 0;

  bcd_counter_multi #(.DIGITS(2), .WRAP_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(count), .carry(carry), .tc(tc), .load_err(load_err));

  bcd_counter_multi #(.DIGITS(2), .WRAP_EN(1'b0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(s_en), .up_dn(s_up_dn), .load(s_load),
    .load_val(s_load_val), .count(s_count), .carry(s_carry), .tc(s_tc), .load_err(s_load_err));

  bcd_counter_multi #(.DIGITS(2), .WRAP_EN(1'b1)) chain_lo (
    .clk(clk), .rst_n(rst_n), .en(c_en), .up_dn(c_up_dn), .load(c_load),
    .load_val(lo_val), .count(lo_count), .carry(lo_carry), .tc(lo_tc), .load_err(lo_err));

  bcd_counter_multi #(.DIGITS(2), .WRAP_EN(1'b1)) chain_hi (
    .clk(clk), .rst_n(rst_n), .en(lo_tc), .up_dn(c_up_dn), .load(c_load),
    .load_val(hi_val), .count(hi_count), .carry(hi_carry), .tc(hi_tc), .load_err(hi_err));

  bcd_counter_multi #(.DIGITS(1), .WRAP_EN(1'b1)) dut_one (
    .clk(clk), .rst_n(rst_n), .en(o_en), .up_dn(o_up_dn), .load(o_load),
    .load_val(o_val), .count(o_count), .carry(o_carry), .tc(o_tc), .load_err(o_err));

  // Advance one edge and settle past it before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] exp_cnt;
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'h00;
    tick(); tick();
    n_cmp++;
    if (count !== 8'h00) begin n_err++; $display("[TB] FAIL reset_count got %h exp 00", count); end
    n_cmp++;
    if (carry !== 1'b0) begin n_err++; $display("[TB] FAIL reset_carry got %b exp 0", carry); end
    n_cmp++;
    if (load_err !== 1'b0) begin n_err++; $display("[TB] FAIL reset_load_err got %b exp 0", load_err); end
    rst_n = 1'b1; en = 1'b1; up_dn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      exp_cnt = (i < 10) ? 8'(i) : 8'h10;
      n_cmp++;
      if (count !== exp_cnt) begin n_err++; $display("[TB] FAIL count_up_%0d got %h exp %h", i, count, exp_cnt); end
      n_cmp++;
      if (carry !== 1'b0) begin n_err++; $display("[TB] FAIL count_up_carry_%0d got %b exp 0", i, carry); end
    end
  endtask

  task automatic test_wrap_up();
    en = 1'b1; up_dn = 1'b1; load = 1'b1; load_val = 8'h98;
    tick();
    n_cmp++;
    if (count !== 8'h98) begin n_err++; $display("[TB] FAIL wrap_up_load got %h exp 98", count); end
    load = 1'b0;
    tick();
    n_cmp++;
    if (count !== 8'h99) begin n_err++; $display("[TB] FAIL wrap_up_99 got %h exp 99", count); end
    n_cmp++;
    if (tc !== 1'b1) begin n_err++; $display("[TB] FAIL wrap_up_tc got %b exp 1", tc); end
    tick();
    n_cmp++;
    if (count !== 8'h00) begin n_err++; $display("[TB] FAIL wrap_up_00 got %h exp 00", count); end
    n_cmp++;
    if (carry !== 1'b1) begin n_err++; $display("[TB] FAIL wrap_up_carry got %b exp 1", carry); end
    tick();
    n_cmp++;
    if (count !== 8'h01) begin n_err++; $display("[TB] FAIL wrap_up_01 got %h exp 01", count); end
    n_cmp++;
    if (carry !== 1'b0) begin n_err++; $display("[TB] FAIL wrap_up_carry_drop got %b exp 0", carry); end
  endtask

  task automatic test_wrap_down();
    en = 1'b0; load = 1'b1; load_val = 8'h00;
    tick();
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    #1;
    n_cmp++;
    if (tc !== 1'b1) begin n_err++; $display("[TB] FAIL wrap_dn_tc got %b exp 1", tc); end
    tick();
    n_cmp++;
    if (count !== 8'h99) begin n_err++; $display("[TB] FAIL wrap_dn_99 got %h exp 99", count); end
    n_cmp++;
    if (carry !== 1'b1) begin n_err++; $display("[TB] FAIL wrap_dn_carry got %b exp 1", carry); end
    tick();
    n_cmp++;
    if (count !== 8'h98) begin n_err++; $display("[TB] FAIL wrap_dn_98 got %h exp 98", count); end
    n_cmp++;
    if (carry !== 1'b0) begin n_err++; $display("[TB] FAIL wrap_dn_carry_drop got %b exp 0", carry); end
    // Borrow across decades: 98 -> 90 -> 89
    load = 1'b1; load_val = 8'h90;
    tick();
    load = 1'b0;
    tick();
    n_cmp++;
    if (count !== 8'h89) begin n_err++; $display("[TB] FAIL borrow_89 got %h exp 89", count); end
  endtask

  task automatic test_load();
    en = 1'b0; up_dn = 1'b1; load = 1'b1; load_val = 8'hA5;
    tick();
    n_cmp++;
    if (count !== 8'h95) begin n_err++; $display("[TB] FAIL load_clamp got %h exp 95", count); end
    n_cmp++;
    if (load_err !== 1'b1) begin n_err++; $display("[TB] FAIL load_err_set got %b exp 1", load_err); end
    load = 1'b0;
    tick();
    n_cmp++;
    if (load_err !== 1'b0) begin n_err++; $display("[TB] FAIL load_err_drop got %b exp 0", load_err); end
    n_cmp++;
    if (count !== 8'h95) begin n_err++; $display("[TB] FAIL hold_95 got %h exp 95", count); end
    load = 1'b1; load_val = 8'h99;
    tick();
    en = 1'b1; load_val = 8'h12;
    tick();
    n_cmp++;
    if (count !== 8'h12) begin n_err++; $display("[TB] FAIL load_priority got %h exp 12", count); end
    n_cmp++;
    if (carry !== 1'b0) begin n_err++; $display("[TB] FAIL load_no_carry got %b exp 0", carry); end
    // Direction change applies on the same edge
    load = 1'b0; up_dn = 1'b0;
    tick();
    n_cmp++;
    if (count !== 8'h11) begin n_err++; $display("[TB] FAIL dir_change got %h exp 11", count); end
    n_cmp++;
    if (carry !== 1'b0) begin n_err++; $display("[TB] FAIL dir_change_carry got %b exp 0", carry); end
  endtask

  task automatic test_saturate();
    logic [7:0] exp_sat [5];
    exp_sat = '{8'h98, 8'h99, 8'h99, 8'h99, 8'h99};
    s_en = 1'b0; s_up_dn = 1'b1; s_load = 1'b1; s_load_val = 8'h97;
    tick();
    s_load = 1'b0; s_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++;
      if (s_count !== exp_sat[i]) begin n_err++; $display("[TB] FAIL sat_count_%0d got %h exp %h", i, s_count, exp_sat[i]); end
      n_cmp++;
      if (s_carry !== 1'b0) begin n_err++; $display("[TB] FAIL sat_carry_%0d got %b exp 0", i, s_carry); end
      n_cmp++;
      if (s_tc !== (exp_sat[i] == 8'h99)) begin n_err++; $display("[TB] FAIL sat_tc_%0d got %b exp %b", i, s_tc, exp_sat[i] == 8'h99); end
    end
    s_up_dn = 1'b0; s_load = 1'b1; s_load_val = 8'h00;
    tick();
    s_load = 1'b0;
    tick();
    n_cmp++;
    if (s_count !== 8'h00) begin n_err++; $display("[TB] FAIL sat_down got %h exp 00", s_count); end
    s_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    en = 1'b0; up_dn = 1'b1; load = 1'b1; load_val = 8'h42;
    tick();
    load = 1'b0; en = 1'b1; rst_n = 1'b0;
    tick();
    n_cmp++;
    if (count !== 8'h00) begin n_err++; $display("[TB] FAIL mid_reset got %h exp 00", count); end
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (count !== 8'h01) begin n_err++; $display("[TB] FAIL after_reset got %h exp 01", count); end
    en = 1'b0;
  endtask

  task automatic test_chain();
    c_en = 1'b0; c_up_dn = 1'b1; c_load = 1'b1; lo_val = 8'h99; hi_val = 8'h00;
    tick();
    c_load = 1'b0; c_en = 1'b1;
    #1;
    n_cmp++;
    if (lo_tc !== 1'b1) begin n_err++; $display("[TB] FAIL chain_lo_tc got %b exp 1", lo_tc); end
    n_cmp++;
    if (hi_tc !== 1'b0) begin n_err++; $display("[TB] FAIL chain_hi_tc got %b exp 0", hi_tc); end
    tick();
    n_cmp++;
    if ({hi_count, lo_count} !== 16'h0100) begin n_err++; $display("[TB] FAIL chain_0100 got %h exp 0100", {hi_count, lo_count}); end
    tick();
    n_cmp++;
    if ({hi_count, lo_count} !== 16'h0101) begin n_err++; $display("[TB] FAIL chain_0101 got %h exp 0101", {hi_count, lo_count}); end
    c_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    o_en = 1'b0; o_up_dn = 1'b1; o_load = 1'b1; o_val = 4'h9;
    tick();
    o_load = 1'b0; o_en = 1'b1;
    tick();
    n_cmp++;
    if (o_count !== 4'h0) begin n_err++; $display("[TB] FAIL b2b_wrap_up got %h exp 0", o_count); end
    n_cmp++;
    if (o_carry !== 1'b1) begin n_err++; $display("[TB] FAIL b2b_carry1 got %b exp 1", o_carry); end
    o_up_dn = 1'b0;
    tick();
    n_cmp++;
    if (o_count !== 4'h9) begin n_err++; $display("[TB] FAIL b2b_wrap_dn got %h exp 9", o_count); end
    n_cmp++;
    if (o_carry !== 1'b0) begin n_err++; $display("[TB] FAIL b2b_carry2 got %b exp 0", o_carry); end
    tick();
    n_cmp++;
    if (o_count !== 4'h8) begin n_err++; $display("[TB] FAIL b2b_8 got %h exp 8", o_count); end
    o_en = 1'b0;
  endtask

  initial begin
    s_en = 1'b0; s_up_dn = 1'b1; s_load = 1'b0; s_load_val = 8'h00;
    c_en = 1'b0; c_up_dn = 1'b1; c_load = 1'b0; lo_val = 8'h00; hi_val = 8'h00;
    o_en = 1'b0; o_up_dn = 1'b1; o_load = 1'b0; o_val = 4'h0;
    #2;
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_load();
    test_saturate();
    test_reset_mid();
    test_chain();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
